nic_ctrl_sched: RTL and testbench

NIC_CTRL_SCHED -- requirements
Module: nic_ctrl_sched

---
 rtl/nic_ctrl_sched.sv | 218 +++++++++++++++++++++
 tb/tb_nic_ctrl_sched.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nic_ctrl_sched.sv
// Host-to-NIC scheduler: queues host TX packets and alternates between writing them
// to the NIC output buffer and fetching packets from the NIC input buffer.
module nic_ctrl_sched #(
    parameter int PACKET_WIDTH = 64,
    parameter int TXQ_DEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tx_valid,
    input  logic [PACKET_WIDTH-1:0] tx_data,
    output logic                    tx_ready,
    output logic                    rx_valid,
    output logic [PACKET_WIDTH-1:0] rx_data,
    input  logic                    rx_ready,
    output logic [1:0]              addr,
    output logic [PACKET_WIDTH-1:0] d_out,
    input  logic [PACKET_WIDTH-1:0] d_in,
    output logic                    nicEn,
    output logic                    nicEnWR,
    output logic [15:0]             tx_count,
    output logic [15:0]             rx_count,
    output logic                    busy
);

    localparam int AW = $clog2(TXQ_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        POLL_OUT  = 3'd1,
        WRITE_OUT = 3'd2,
        POLL_IN   = 3'd3,
        READ_IN   = 3'd4
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic [PACKET_WIDTH-1:0] fifo_mem_r [TXQ_DEPTH];
    logic [AW:0]             wr_ptr_r;
    logic [AW:0]             rd_ptr_r;
    logic [AW:0]             wr_ptr_next_s;
    logic [AW:0]             rd_ptr_next_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    fifo_empty_s;
    logic                    full_next_s;
    logic [PACKET_WIDTH-1:0] fifo_head_s;
    logic                    last_tx_r;
    logic                    tx_elig_s;
    logic                    rx_elig_s;
    logic                    nic_en_s;
    logic                    nic_wr_s;
    logic [1:0]              addr_s;
    logic [PACKET_WIDTH-1:0] d_out_s;

    assign push_s       = tx_valid && tx_ready;
    assign pop_s        = (state_r == WRITE_OUT);
    assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
    assign fifo_head_s  = fifo_mem_r[rd_ptr_r[AW-1:0]];
    assign tx_elig_s    = !fifo_empty_s;
    assign rx_elig_s    = !rx_valid;

    // Next FIFO pointers and the full flag they imply
    always_comb begin
        wr_ptr_next_s = wr_ptr_r;
        rd_ptr_next_s = rd_ptr_r;
        if (push_s) begin
            wr_ptr_next_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_next_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
        full_next_s = (wr_ptr_next_s[AW] != rd_ptr_next_s[AW]) &&
                      (wr_ptr_next_s[AW-1:0] == rd_ptr_next_s[AW-1:0]);
    end

    // FIFO pointers and registered ready flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
            tx_ready <= 1'b1;
        end else begin
            wr_ptr_r <= wr_ptr_next_s;
            rd_ptr_r <= rd_ptr_next_s;
            tx_ready <= !full_next_s;
        end
    end

    // FIFO storage; contents are don't-care while the pointers mark them empty
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r[AW-1:0]] <= tx_data;
        end
    end

    // Next-state logic; IDLE arbitrates round-robin when both sides are eligible
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (tx_elig_s && rx_elig_s) begin
                    state_next_s = last_tx_r ? POLL_IN : POLL_OUT;
                end else if (tx_elig_s) begin
                    state_next_s = POLL_OUT;
                end else if (rx_elig_s) begin
                    state_next_s = POLL_IN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            POLL_OUT: begin
                if (!d_in[0]) begin
                    state_next_s = WRITE_OUT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WRITE_OUT: state_next_s = IDLE;
            POLL_IN: begin
                if (d_in[0]) begin
                    state_next_s = READ_IN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            READ_IN: state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // NIC bus decode of the upcoming state, so the registered outputs match the state
    always_comb begin
        nic_en_s = 1'b0;
        nic_wr_s = 1'b0;
        addr_s   = 2'b00;
        d_out_s  = {PACKET_WIDTH{1'b0}};
        case (state_next_s)
            POLL_OUT: begin
                nic_en_s = 1'b1;
                addr_s   = 2'b11;
            end
            WRITE_OUT: begin
                nic_en_s = 1'b1;
                nic_wr_s = 1'b1;
                addr_s   = 2'b10;
                d_out_s  = fifo_head_s;
            end
            POLL_IN: begin
                nic_en_s = 1'b1;
                addr_s   = 2'b01;
            end
            READ_IN: begin
                nic_en_s = 1'b1;
                addr_s   = 2'b00;
            end
            default: begin
                nic_en_s = 1'b0;
            end
        endcase
    end

    // State register and registered NIC bus outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            nicEn   <= 1'b0;
            nicEnWR <= 1'b0;
            addr    <= 2'b00;
            d_out   <= {PACKET_WIDTH{1'b0}};
            busy    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            nicEn   <= nic_en_s;
            nicEnWR <= nic_wr_s;
            addr    <= addr_s;
            d_out   <= d_out_s;
            busy    <= (state_next_s != IDLE);
        end
    end

    // Last-served flag, updated on leaving a poll whatever its outcome
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_tx_r <= 1'b0;
        end else if (state_r == POLL_OUT) begin
            last_tx_r <= 1'b1;
        end else if (state_r == POLL_IN) begin
            last_tx_r <= 1'b0;
        end
    end

    // Received packet holding register and transfer counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_valid <= 1'b0;
            rx_data  <= {PACKET_WIDTH{1'b0}};
            tx_count <= 16'd0;
            rx_count <= 16'd0;
        end else begin
            if (state_r == READ_IN) begin
                rx_valid <= 1'b1;
                rx_data  <= d_in;
                rx_count <= rx_count + 16'd1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (state_r == WRITE_OUT) begin
                tx_count <= tx_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_nic_ctrl_sched.sv
// Directed bench for nic_ctrl_sched: a small NIC register model answers polls and
// reads, a monitor logs writes, and hand-derived expectations are checked.
module tb_nic_ctrl_sched;

    localparam int PW = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          tx_valid;
    logic [PW-1:0] tx_data;
    logic          tx_ready;
    logic          rx_valid;
    logic [PW-1:0] rx_data;
    logic          rx_ready;
    logic [1:0]    addr;
    logic [PW-1:0] d_out;
    logic [PW-1:0] d_in;
    logic          nicEn;
    logic          nicEnWR;
    logic [15:0]   tx_count;
    logic [15:0]   rx_count;
    logic          busy;

    logic          out_full;
    logic          in_full;
    logic [PW-1:0] in_data;

    int            out_polls = 0;
    int            in_polls  = 0;
    logic [PW-1:0] wr_q[$];

    int            n_checks = 0;
    int            n_pass   = 0;
    int            p0;
    int            i0;
    logic          found;
    logic          stable;

    nic_ctrl_sched #(.PACKET_WIDTH(PW), .TXQ_DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .addr     (addr),
        .d_out    (d_out),
        .d_in     (d_in),
        .nicEn    (nicEn),
        .nicEnWR  (nicEnWR),
        .tx_count (tx_count),
        .rx_count (rx_count),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // NIC register file: read data follows the selected address in the same cycle
    always_comb begin
        d_in = {PW{1'b0}};
        case (addr)
            2'b00:   d_in = in_data;
            2'b01:   d_in = {63'd0, in_full};
            2'b11:   d_in = {63'd0, out_full};
            default: d_in = {PW{1'b0}};
        endcase
    end

    // Bus monitor: counts polls and logs every write to the output buffer
    always @(posedge clk) begin
        if (reset && nicEn) begin
            if (nicEnWR && addr == 2'b10) wr_q.push_back(d_out);
            if (!nicEnWR && addr == 2'b11) out_polls <= out_polls + 1;
            if (!nicEnWR && addr == 2'b01) in_polls <= in_polls + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        out_full = 1'b0;
        in_full  = 1'b0;
        repeat (3) tick();
        wr_q.delete();
        reset = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 64'd0;
        rx_ready = 1'b0;
        out_full = 1'b0;
        in_full  = 1'b0;
        in_data  = 64'd0;

        // Reset values after three cycles low
        repeat (3) tick();
        check("rst_tx_ready", tx_ready, 64'd1);
        check("rst_rx_valid", rx_valid, 64'd0);
        check("rst_rx_data",  rx_data,  64'd0);
        check("rst_tx_count", tx_count, 64'd0);
        check("rst_rx_count", rx_count, 64'd0);
        check("rst_bus",      {nicEn, nicEnWR, addr}, 64'd0);
        check("rst_d_out",    d_out,    64'd0);
        check("rst_busy",     busy,     64'd0);
        reset = 1'b1;
        #1;
        check("rel_nicen", nicEn, 64'd0);
        repeat (20) tick();
        check("idle_no_write", wr_q.size(), 64'd0);
        check("idle_in_polls", (in_polls > 0), 64'd1);

        // Single TX, launched as an input poll ends so IDLE follows the push
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (nicEn && !nicEnWR && addr == 2'b01) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("sync_poll_in", found, 64'd1);
        tx_valid = 1'b1;
        tx_data  = 64'hA5;
        tick();
        tx_valid = 1'b0;
        check("k1_idle", {busy, nicEn}, 64'd0);
        tick();
        check("k2_poll_out", {nicEn, nicEnWR, addr}, 64'b1011);
        tick();
        check("k3_write", {nicEn, nicEnWR, addr}, 64'b1110);
        check("k3_d_out", d_out, 64'hA5);
        tick();
        check("tx1_count", tx_count, 64'd1);
        check("tx1_nwr", wr_q.size(), 64'd1);
        if (wr_q.size() > 0) check("tx1_data", wr_q[0], 64'hA5);

        // Back-pressure: output buffer full for five polls
        do_reset();
        out_full = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 64'hB7;
        tick();
        tx_valid = 1'b0;
        p0 = out_polls;
        i0 = in_polls;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (out_polls - p0 >= 5) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("bp_polls_seen", found, 64'd1);
        check("bp_no_write", wr_q.size(), 64'd0);
        check("bp_tx_count0", tx_count, 64'd0);
        check("bp_interleave", ((in_polls - i0) >= 4), 64'd1);
        out_full = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (wr_q.size() >= 1) break;
            tick();
        end
        repeat (10) tick();
        check("bp_nwr", wr_q.size(), 64'd1);
        if (wr_q.size() > 0) check("bp_data", wr_q[0], 64'hB7);
        check("bp_tx_count", tx_count, 64'd1);

        // FIFO limit: four entries accepted, fifth refused
        do_reset();
        out_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tx_valid = 1'b1;
            tx_data  = 64'hC1 + 64'(i);
            check("fifo_ready", tx_ready, 64'd1);
            tick();
        end
        tx_data = 64'hC5;
        check("fifo_full", tx_ready, 64'd0);
        tick();
        check("fifo_full_hold", tx_ready, 64'd0);
        tx_valid = 1'b0;
        out_full = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (wr_q.size() >= 4) break;
            tick();
        end
        repeat (10) tick();
        check("fifo_nwr", wr_q.size(), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (wr_q.size() > i) check("fifo_order", wr_q[i], 64'hC1 + 64'(i));
        end
        check("fifo_tx_count", tx_count, 64'd4);
        check("fifo_ready_back", tx_ready, 64'd1);

        // RX hold while the host is not ready
        do_reset();
        in_full = 1'b1;
        in_data = 64'h1234;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rx_valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("rx_got", found, 64'd1);
        check("rx_data1", rx_data, 64'h1234);
        check("rx_count1", rx_count, 64'd1);
        in_data = 64'h5678;
        p0 = in_polls;
        stable = 1'b1;
        repeat (10) begin
            tick();
            if (!(rx_valid === 1'b1 && rx_data === 64'h1234)) stable = 1'b0;
        end
        check("rx_stable", stable, 64'd1);
        check("rx_no_poll", in_polls - p0, 64'd0);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check("rx_cleared", rx_valid, 64'd0);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rx_valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("rx_got2", found, 64'd1);
        check("rx_data2", rx_data, 64'h5678);
        check("rx_count2", rx_count, 64'd2);

        // Reset dropped in the middle of a write
        do_reset();
        tx_valid = 1'b1;
        tx_data  = 64'hD9;
        tick();
        tx_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (nicEn && nicEnWR) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("mid_write_seen", found, 64'd1);
        reset = 1'b0;
        #1;
        check("mid_bus", {nicEn, nicEnWR, addr}, 64'd0);
        check("mid_busy", busy, 64'd0);
        check("mid_tx_count", tx_count, 64'd0);
        check("mid_tx_ready", tx_ready, 64'd1);
        tick();
        reset = 1'b1;
        repeat (20) tick();
        check("mid_no_write", wr_q.size(), 64'd0);
        check("mid_tx_count2", tx_count, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
